// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address and timing controller for the RiSC-16 FPGA program counter.
// Latency: address_next/wait_cycle/commit are combinational from instr/pc_cur and the cycle mirror; state updates on the commit edge.
// Backpressure: stall_req in the commit cycle suppresses commit and replays the instruction for a full period.
//
// Ports:
//   clk0, reset          clock and synchronous active-low reset
//   instr, pc_cur        instruction at the current PC and the PC value itself
//   eq_flag              regA==regB from the datapath (BEQ decision)
//   jalr_target          regB contents for JALR
//   stall_req            memory busy, only looked at in the commit cycle
//   address_next         to PC address_in
//   wait_cycle           to PC wait_cycle
//   commit               high in the cycle the current instruction retires
//   link_addr            zero-extended pc_cur+1 for JALR writeback
//   halted               core halted, cleared only by reset
//   instr_count          saturating retired-instruction counter
//   dbg_hold, dbg_step   single-step controls, present only with PCSEQ_SINGLE_STEP_EN
//
// Optional feature macro: PCSEQ_SINGLE_STEP_EN (adds STEP_HOLD state and the dbg_* inputs).
module pc_sequencer #(
   parameter int         ADDR_W   = 6,
   parameter logic [1:0] WAIT_ALU = 2'd1,
   parameter logic [1:0] WAIT_MEM = 2'd2,
   parameter logic [1:0] WAIT_BR  = 2'd1
) (
   input  logic              clk0,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic [ADDR_W-1:0] pc_cur,
   input  logic              eq_flag,
   input  logic [15:0]       jalr_target,
   input  logic              stall_req,
`ifdef PCSEQ_SINGLE_STEP_EN
   input  logic              dbg_hold,
   input  logic              dbg_step,
`endif
   output logic [ADDR_W-1:0] address_next,
   output logic [1:0]        wait_cycle,
   output logic              commit,
   output logic [15:0]       link_addr,
   output logic              halted,
   output logic [15:0]       instr_count
);

`ifdef PCSEQ_SINGLE_STEP_EN
   typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_STEP_HOLD} state_t;
`else
   typedef enum logic {ST_RUN, ST_HALT} state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  cyc_q, cyc_d;
   logic [15:0] count_q, count_d;
`ifdef PCSEQ_SINGLE_STEP_EN
   // Set by a dbg_step pulse while held; lets one instruction run to commit.
   logic        step_q, step_d;
`endif

   // ---------------- decode ----------------
   logic [2:0] opcode;
   logic       is_mem, is_beq, is_jalr, is_halt;
   logic [1:0] class_wait;

   assign opcode  = instr[15:13];
   assign is_mem  = (opcode[2:1] == 2'b10);
   assign is_beq  = (opcode == 3'b110);
   assign is_jalr = (opcode == 3'b111);
   assign is_halt = is_jalr && (instr[6:0] != 7'd0);

   always_comb begin
      class_wait = WAIT_ALU;
      if (is_mem)
         class_wait = WAIT_MEM;
      else if (is_beq || is_jalr)
         class_wait = WAIT_BR;
   end

   // "active" means the instruction at pc_cur is allowed to execute its period.
   logic active;
`ifdef PCSEQ_SINGLE_STEP_EN
   assign active = (state_q == ST_RUN) || ((state_q == ST_STEP_HOLD) && step_q);
`else
   assign active = (state_q == ST_RUN);
`endif

   // When not active the PC is parked on itself with a zero wait, so both the PC's
   // counter and our mirror sit at 0 and stay aligned for the next real period.
   assign wait_cycle = active ? class_wait : 2'd0;

   logic boundary;
   assign boundary = (cyc_q == wait_cycle);
   assign commit   = active && boundary && !stall_req;

   // ---------------- address arithmetic (mod 2^ADDR_W) ----------------
   logic [15:0]       pc_ext, br_sum;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_ext    = 16'(pc_cur);
   assign pc_inc    = pc_cur + ADDR_W'(1);
   assign br_sum    = pc_ext + 16'd1 + {{9{instr[6]}}, instr[6:0]};
   // Link value is taken before truncation: pc 63 links to 16'h0040.
   assign link_addr = pc_ext + 16'd1;

   always_comb begin
      address_next = pc_inc;
      if (!active || stall_req || is_halt)
         address_next = pc_cur;
      else if (is_beq && eq_flag)
         address_next = br_sum[ADDR_W-1:0];
      else if (is_jalr)
         address_next = jalr_target[ADDR_W-1:0];
   end

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      cyc_d   = boundary ? 2'd0 : cyc_q + 2'd1;
      count_d = (commit && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
`ifdef PCSEQ_SINGLE_STEP_EN
      step_d  = step_q;
`endif
      case (state_q)
         ST_RUN: begin
            if (commit) begin
               if (is_halt)
                  state_d = ST_HALT;
`ifdef PCSEQ_SINGLE_STEP_EN
               else if (dbg_hold)
                  state_d = ST_STEP_HOLD;
`endif
            end
         end
         ST_HALT: state_d = ST_HALT;
`ifdef PCSEQ_SINGLE_STEP_EN
         ST_STEP_HOLD: begin
            if (step_q) begin
               if (commit) begin
                  step_d = 1'b0;
                  if (is_halt)
                     state_d = ST_HALT;
                  else if (!dbg_hold)
                     state_d = ST_RUN;
               end
            end else if (!dbg_hold) begin
               state_d = ST_RUN;
            end else if (dbg_step) begin
               step_d = 1'b1;
            end
         end
`endif
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk0) begin
      if (!reset) begin
         state_q <= ST_RUN;
         cyc_q   <= 2'd0;
         count_q <= 16'd0;
`ifdef PCSEQ_SINGLE_STEP_EN
         step_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         count_q <= count_d;
`ifdef PCSEQ_SINGLE_STEP_EN
         step_q  <= step_d;
`endif
      end
   end

   assign halted      = (state_q == ST_HALT);
   assign instr_count = count_q;

   // Fields not used by the sequencer.
   logic unused_bits;
   assign unused_bits = ^{instr[12:7], jalr_target[15:ADDR_W], br_sum[15:ADDR_W]};

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   logic        clk0 = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic [5:0]  pc_cur;
   logic        eq_flag;
   logic [15:0] jalr_target;
   logic        stall_req;
`ifdef PCSEQ_SINGLE_STEP_EN
   logic        dbg_hold;
   logic        dbg_step;
`endif
   logic [5:0]  address_next;
   logic [1:0]  wait_cycle;
   logic        commit;
   logic [15:0] link_addr;
   logic        halted;
   logic [15:0] instr_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk0 = ~clk0;

   pc_sequencer #(.ADDR_W(6), .WAIT_ALU(2'd1), .WAIT_MEM(2'd2), .WAIT_BR(2'd1)) dut (
      .clk0        (clk0),
      .reset       (reset),
      .instr       (instr),
      .pc_cur      (pc_cur),
      .eq_flag     (eq_flag),
      .jalr_target (jalr_target),
      .stall_req   (stall_req),
`ifdef PCSEQ_SINGLE_STEP_EN
      .dbg_hold    (dbg_hold),
      .dbg_step    (dbg_step),
`endif
      .address_next(address_next),
      .wait_cycle  (wait_cycle),
      .commit      (commit),
      .link_addr   (link_addr),
      .halted      (halted),
      .instr_count (instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk0);
      #1;
   endtask

   initial begin
      reset       = 1'b0;
      instr       = 16'h0000;
      pc_cur      = 6'd0;
      eq_flag     = 1'b0;
      jalr_target = 16'h0000;
      stall_req   = 1'b0;
`ifdef PCSEQ_SINGLE_STEP_EN
      dbg_hold    = 1'b0;
      dbg_step    = 1'b0;
`endif
      tick();
      tick();
      chk("rst_halted", halted, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_commit", commit, 0);

      // ADD at pc 0: wait 1, commits on the second cycle.
      reset = 1'b1;
      #1;
      chk("add_wait", wait_cycle, 1);
      chk("add_c0_commit", commit, 0);
      tick();
      chk("add_c1_commit", commit, 1);
      chk("add_next", address_next, 1);
      chk("add_link", link_addr, 16'h0001);
      tick();
      chk("add_count", instr_count, 1);

      // LW at pc 5: stall before the commit cycle is ignored, stall in it replays.
      pc_cur = 6'd5; instr = 16'hA000;
      #1;
      chk("lw_wait", wait_cycle, 2);
      tick();
      stall_req = 1'b1;
      #1;
      chk("lw_c1_commit", commit, 0);
      tick();
      chk("lw_stall_commit", commit, 0);
      chk("lw_stall_next", address_next, 5);
      tick();
      chk("lw_stall_count", instr_count, 1);
      tick();
      tick();
      stall_req = 1'b0;
      #1;
      chk("lw_replay_commit", commit, 1);
      chk("lw_replay_next", address_next, 6);
      tick();
      chk("lw_count", instr_count, 2);

      // BEQ at pc 10, offset -4.
      pc_cur = 6'd10; instr = 16'hC07C; eq_flag = 1'b1;
      #1;
      chk("beq_wait", wait_cycle, 1);
      tick();
      chk("beq_commit", commit, 1);
      chk("beq_taken", address_next, 7);
      eq_flag = 1'b0;
      #1;
      chk("beq_not_taken", address_next, 11);
      tick();
      chk("beq_count", instr_count, 3);

      // BEQ at pc 1, offset -4 wraps below zero to 62.
      pc_cur = 6'd1; eq_flag = 1'b1;
      tick();
      chk("beq_wrap", address_next, 62);
      tick();
      eq_flag = 1'b0;

      // JALR at pc 63.
      pc_cur = 6'd63; instr = 16'hE000; jalr_target = 16'h0042;
      #1;
      chk("jalr_link", link_addr, 16'h0040);
      tick();
      chk("jalr_commit", commit, 1);
      chk("jalr_next", address_next, 2);
      tick();

      // ADDI at pc 63 wraps to 0.
      instr = 16'h2000;
      tick();
      chk("addi_wrap", address_next, 0);
      tick();
      chk("addi_count", instr_count, 6);

      // Remaining class waits (combinational, at cycle 0).
      instr = 16'h4000; #1; chk("nand_wait", wait_cycle, 1);
      instr = 16'h6000; #1; chk("lui_wait", wait_cycle, 1);
      instr = 16'h8000; #1; chk("sw_wait", wait_cycle, 2);

      // HALT at pc 20.
      pc_cur = 6'd20; instr = 16'hE001;
      #1;
      chk("halt_c0_next", address_next, 20);
      tick();
      chk("halt_commit", commit, 1);
      chk("halt_next", address_next, 20);
      tick();
      chk("halted", halted, 1);
      chk("halt_count", instr_count, 7);
      chk("halt_wait", wait_cycle, 0);
      tick();
      tick();
      tick();
      instr = 16'h0000;
      #1;
      chk("halt_frozen_count", instr_count, 7);
      chk("halt_frozen_commit", commit, 0);
      chk("halt_frozen_next", address_next, 20);
      reset = 1'b0;
      tick();
      chk("rst2_halted", halted, 0);
      chk("rst2_count", instr_count, 0);
      reset = 1'b1;

      // Reset mid-instruction restarts the period.
      pc_cur = 6'd7; instr = 16'hA000;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      chk("midrst_c0_commit", commit, 0);
      tick();
      chk("midrst_c1_commit", commit, 0);
      tick();
      chk("midrst_c2_commit", commit, 1);
      chk("midrst_next", address_next, 8);
      tick();
      chk("midrst_count", instr_count, 1);

`ifdef PCSEQ_SINGLE_STEP_EN
      // Hold during an ADD stream: the current ADD finishes, then execution freezes.
      pc_cur = 6'd0; instr = 16'h0000; dbg_hold = 1'b1;
      #1;
      chk("dbg_c0_commit", commit, 0);
      tick();
      chk("dbg_finish_commit", commit, 1);
      tick();
      pc_cur = 6'd1;
      tick();
      tick();
      chk("dbg_hold_commit", commit, 0);
      chk("dbg_hold_wait", wait_cycle, 0);
      chk("dbg_hold_next", address_next, 1);
      chk("dbg_hold_count", instr_count, 2);
      dbg_step = 1'b1;
      tick();
      dbg_step = 1'b0;
      #1;
      chk("dbg_step_c0_commit", commit, 0);
      chk("dbg_step_wait", wait_cycle, 1);
      tick();
      chk("dbg_step_commit", commit, 1);
      chk("dbg_step_next", address_next, 2);
      tick();
      pc_cur = 6'd2;
      #1;
      chk("dbg_rehold_commit", commit, 0);
      chk("dbg_rehold_wait", wait_cycle, 0);
      tick();
      tick();
      chk("dbg_step_count", instr_count, 3);
      dbg_hold = 1'b0;
      tick();
      chk("dbg_run_wait", wait_cycle, 1);
      chk("dbg_run_c0_commit", commit, 0);
      tick();
      chk("dbg_run_commit", commit, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
